// File: rtl/async_fifo_flag.sv
// Dual-clock FIFO with Gray-coded pointer crossing, occupancy counts and
// almost-full/almost-empty flags on both sides; optional show-ahead read port.
module async_fifo_flag #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SHOW_AHEAD  = 1,
  parameter int unsigned AFULL_TH    = 480,
  parameter int unsigned AEMPTY_TH   = 32
) (
  input  logic              rst_n,
  input  logic              wrclk,
  input  logic              rdclk,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] wrdin,
  output logic              wrfull,
  output logic              wrafull,
  output logic [ADDR_W:0]   wrusedw,
  output logic              wroverflow,
  input  logic              rdreq,
  output logic [DATA_W-1:0] rddout,
  output logic              rdempty,
  output logic              rdaempty,
  output logic [ADDR_W:0]   rdusedw,
  output logic              rdunderflow
);

  localparam int unsigned PtrW  = ADDR_W + 1;
  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [PtrW-1:0] AFullTh  = PtrW'(AFULL_TH);
  localparam logic [PtrW-1:0] AEmptyTh = PtrW'(AEMPTY_TH);

  function automatic logic [PtrW-1:0] bin2gray(input logic [PtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
    logic [PtrW-1:0] b;
    b[PtrW-1] = g[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_W-1:0] mem [Depth];

  // Write domain
  logic [PtrW-1:0] wr_bin_q, wr_bin_d, wr_gray_q;
  logic [PtrW-1:0] rd_sync_q [SYNC_STAGES];
  logic [PtrW-1:0] rd_gray_wsync, rd_bin_wsync;
  logic            wr_en, wroverflow_q;

  // Read domain
  logic [PtrW-1:0] rd_bin_q, rd_bin_d, rd_gray_q;
  logic [PtrW-1:0] wr_sync_q [SYNC_STAGES];
  logic [PtrW-1:0] wr_gray_rsync, wr_bin_rsync;
  logic            rd_en, rdunderflow_q;
  logic [DATA_W-1:0] rd_word;

  assign rd_gray_wsync = rd_sync_q[SYNC_STAGES-1];
  assign rd_bin_wsync  = gray2bin(rd_gray_wsync);

  // Full when the writer is exactly one lap ahead of the (stale) read pointer.
  assign wrfull   = (wr_gray_q == {~rd_gray_wsync[PtrW-1 -: 2], rd_gray_wsync[PtrW-3:0]});
  assign wr_en    = wrreq & ~wrfull;
  assign wr_bin_d = wr_bin_q + PtrW'(wr_en);
  assign wrusedw  = wr_bin_q - rd_bin_wsync;
  assign wrafull  = (wrusedw >= AFullTh);
  assign wroverflow = wroverflow_q;

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q     <= '0;
      wr_gray_q    <= '0;
      wroverflow_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        rd_sync_q[i] <= '0;
      end
    end else begin
      wr_bin_q     <= wr_bin_d;
      wr_gray_q    <= bin2gray(wr_bin_d);
      wroverflow_q <= wrreq & wrfull;
      rd_sync_q[0] <= rd_gray_q;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rd_sync_q[i] <= rd_sync_q[i-1];
      end
    end
  end

  always_ff @(posedge wrclk) begin
    if (wr_en) begin
      mem[wr_bin_q[ADDR_W-1:0]] <= wrdin;
    end
  end

  assign wr_gray_rsync = wr_sync_q[SYNC_STAGES-1];
  assign wr_bin_rsync  = gray2bin(wr_gray_rsync);

  assign rdempty  = (rd_gray_q == wr_gray_rsync);
  assign rd_en    = rdreq & ~rdempty;
  assign rd_bin_d = rd_bin_q + PtrW'(rd_en);
  assign rdusedw  = wr_bin_rsync - rd_bin_q;
  assign rdaempty = (rdusedw <= AEmptyTh);
  assign rdunderflow = rdunderflow_q;

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bin_q      <= '0;
      rd_gray_q     <= '0;
      rdunderflow_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        wr_sync_q[i] <= '0;
      end
    end else begin
      rd_bin_q      <= rd_bin_d;
      rd_gray_q     <= bin2gray(rd_bin_d);
      rdunderflow_q <= rdreq & rdempty;
      wr_sync_q[0]  <= wr_gray_q;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        wr_sync_q[i] <= wr_sync_q[i-1];
      end
    end
  end

  // The word at the read pointer is stable once its write has been seen here.
  assign rd_word = mem[rd_bin_q[ADDR_W-1:0]];

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign rddout = rdempty ? '0 : rd_word;
  end else begin : g_normal
    logic [DATA_W-1:0] rddout_q;
    always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) begin
        rddout_q <= '0;
      end else if (rd_en) begin
        rddout_q <= rd_word;
      end
    end
    assign rddout = rddout_q;
  end

endmodule

// File: tb/tb_async_fifo_flag.sv
// Directed and random bench for async_fifo_flag: show-ahead default instance
// plus a small normal-read instance, checked against a data queue.
module tb_async_fifo_flag;

  localparam int Depth      = 512;
  localparam int SyncStages = 2;
  localparam int Target     = 3 * 1024 + 20;

  logic       rst_n, wrclk, rdclk;
  logic       wrreq, rdreq;
  logic [7:0] wrdin, rddout;
  logic       wrfull, wrafull, wroverflow, rdempty, rdaempty, rdunderflow;
  logic [9:0] wrusedw, rdusedw;

  logic       wrreq2, rdreq2;
  logic [7:0] wrdin2, rddout2;
  logic       wrfull2, wrafull2, wroverflow2, rdempty2, rdaempty2, rdunderflow2;
  logic [4:0] wrusedw2, rdusedw2;

  int wr_half = 5;
  int rd_half = 13;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  async_fifo_flag dut (
    .rst_n(rst_n), .wrclk(wrclk), .rdclk(rdclk),
    .wrreq(wrreq), .wrdin(wrdin), .wrfull(wrfull), .wrafull(wrafull),
    .wrusedw(wrusedw), .wroverflow(wroverflow),
    .rdreq(rdreq), .rddout(rddout), .rdempty(rdempty), .rdaempty(rdaempty),
    .rdusedw(rdusedw), .rdunderflow(rdunderflow)
  );

  async_fifo_flag #(
    .DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2), .SHOW_AHEAD(0), .AFULL_TH(12), .AEMPTY_TH(2)
  ) dut_nrm (
    .rst_n(rst_n), .wrclk(wrclk), .rdclk(rdclk),
    .wrreq(wrreq2), .wrdin(wrdin2), .wrfull(wrfull2), .wrafull(wrafull2),
    .wrusedw(wrusedw2), .wroverflow(wroverflow2),
    .rdreq(rdreq2), .rddout(rddout2), .rdempty(rdempty2), .rdaempty(rdaempty2),
    .rdusedw(rdusedw2), .rdunderflow(rdunderflow2)
  );

  initial begin
    wrclk = 1'b0;
    forever #(wr_half) wrclk = ~wrclk;
  end

  initial begin
    rdclk = 1'b0;
    forever #(rd_half) rdclk = ~rdclk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_wrfull"}, wrfull, 0);
    chk({p, "_wrafull"}, wrafull, 0);
    chk({p, "_wrusedw"}, wrusedw, 0);
    chk({p, "_wroverflow"}, wroverflow, 0);
    chk({p, "_rdempty"}, rdempty, 1);
    chk({p, "_rdaempty"}, rdaempty, 1);
    chk({p, "_rdusedw"}, rdusedw, 0);
    chk({p, "_rddout"}, rddout, 0);
    chk({p, "_rdunderflow"}, rdunderflow, 0);
  endtask

  task automatic wait_wr(input int n);
    repeat (n) @(negedge wrclk);
  endtask

  task automatic wait_rd(input int n);
    repeat (n) @(negedge rdclk);
  endtask

  // Drives one write request for the next wrclk edge; queued only if it will be accepted.
  task automatic wr_push(input logic [7:0] d);
    @(negedge wrclk);
    wrdin = d;
    wrreq = 1'b1;
    if (!wrfull) exp_q.push_back(d);
  endtask

  task automatic wr_idle();
    @(negedge wrclk);
    wrreq = 1'b0;
  endtask

  task automatic rd_pop(input string tag);
    logic [7:0] e;
    @(negedge rdclk);
    chk({tag, "_nonempty"}, rdempty, 0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk(tag, rddout, e);
    rdreq = 1'b1;
  endtask

  task automatic rd_idle();
    @(negedge rdclk);
    rdreq = 1'b0;
  endtask

  task automatic writer_proc();
    int pushed = 0;
    int cyc = 0;
    while (pushed < Target && cyc < 40000) begin
      @(negedge wrclk);
      cyc++;
      chk("rand_no_overflow", wroverflow, 0);
      chk("rand_wr_conservative",
          32'(int'(wrusedw) >= exp_q.size() && int'(wrusedw) <= Depth), 1);
      if (!wrfull && $urandom_range(7) != 0) begin
        wrdin = 8'($urandom);
        wrreq = 1'b1;
        exp_q.push_back(wrdin);
        pushed++;
      end else begin
        wrreq = 1'b0;
      end
    end
    @(negedge wrclk);
    wrreq = 1'b0;
    chk("rand_wr_count", pushed, Target);
  endtask

  task automatic reader_proc();
    int popped = 0;
    int cyc = 0;
    logic [7:0] e;
    while (popped < Target && cyc < 40000) begin
      @(negedge rdclk);
      cyc++;
      chk("rand_no_underflow", rdunderflow, 0);
      chk("rand_rd_conservative", 32'(int'(rdusedw) <= exp_q.size()), 1);
      if (!rdempty && $urandom_range(7) != 0) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chk("rand_data", rddout, e);
        rdreq = 1'b1;
        popped++;
      end else begin
        rdreq = 1'b0;
      end
    end
    @(negedge rdclk);
    rdreq = 1'b0;
    chk("rand_rd_count", popped, Target);
  endtask

  task automatic run_random(input int wh, input int rh);
    wr_half = wh;
    rd_half = rh;
    wait_wr(4);
    wait_rd(4);
    fork
      writer_proc();
      reader_proc();
    join
    wait_rd(6);
    wait_wr(6);
    chk("rand_end_rdempty", rdempty, 1);
    chk("rand_end_wrusedw", wrusedw, 0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    wrdin  = '0;
    wrreq2 = 1'b0;
    rdreq2 = 1'b0;
    wrdin2 = '0;

    #20;
    check_reset("reset");
    #83;
    rst_n = 1'b1;
    wait_wr(2);
    wait_rd(2);

    // Read on empty: single underflow pulse, nothing else moves.
    @(negedge rdclk);
    rdreq = 1'b1;
    @(negedge rdclk);
    rdreq = 1'b0;
    chk("underflow_pulse", rdunderflow, 1);
    @(negedge rdclk);
    chk("underflow_single", rdunderflow, 0);
    chk("underflow_rddout", rddout, 0);
    chk("underflow_rdusedw", rdusedw, 0);
    chk("underflow_rdempty", rdempty, 1);

    // First word latency into an empty FIFO, then show-ahead readback.
    wr_push(8'h01);
    wr_idle();
    n = 0;
    while (rdempty && n < 8) begin
      @(posedge rdclk);
      #1;
      n++;
    end
    chk("first_word_latency", 32'(n <= SyncStages + 1 && !rdempty), 1);
    for (int d = 2; d <= 5; d++) wr_push(8'(d));
    wr_idle();
    wait_rd(5);
    chk("five_rdusedw", rdusedw, 5);
    chk("five_rdaempty", rdaempty, 1);
    chk("five_wrusedw", wrusedw, 5);
    for (int i = 0; i < 5; i++) rd_pop("sa_read");
    rd_idle();
    chk("sa_drained_rdempty", rdempty, 1);
    chk("sa_drained_rdusedw", rdusedw, 0);
    wait_wr(5);
    chk("sa_drained_wrusedw", wrusedw, 0);

    // Fill to full with no reads; almost-full threshold and overflow.
    for (int i = 0; i < Depth; i++) begin
      wr_push(8'(i));
      chk("fill_wrusedw", wrusedw, i);
      chk("fill_wrafull", wrafull, 32'(i >= 480));
      chk("fill_wrfull", wrfull, 0);
    end
    wr_push(8'hEE);
    chk("full_wrusedw", wrusedw, Depth);
    chk("full_wrfull", wrfull, 1);
    chk("full_wrafull", wrafull, 1);
    wr_idle();
    chk("overflow_pulse", wroverflow, 1);
    wait_wr(1);
    chk("overflow_single", wroverflow, 0);
    chk("overflow_wrusedw", wrusedw, Depth);
    wait_rd(5);
    chk("full_rdusedw", rdusedw, Depth);
    for (int i = 0; i < Depth; i++) begin
      rd_pop("full_read");
      chk("drain_rdusedw", rdusedw, Depth - i);
      chk("drain_rdaempty", rdaempty, 32'(Depth - i <= 32));
    end
    rd_idle();
    chk("full_drained_rdempty", rdempty, 1);

    // Normal-read instance: data appears one edge after the accepted read and holds.
    @(negedge wrclk);
    wrreq2 = 1'b1;
    wrdin2 = 8'h0A;
    @(negedge wrclk);
    wrdin2 = 8'h0B;
    @(negedge wrclk);
    wrreq2 = 1'b0;
    wait_rd(5);
    chk("nrm_before_read", rddout2, 0);
    chk("nrm_rdusedw", rdusedw2, 2);
    @(negedge rdclk);
    rdreq2 = 1'b1;
    @(negedge rdclk);
    rdreq2 = 1'b0;
    chk("nrm_first", rddout2, 8'h0A);
    wait_rd(3);
    chk("nrm_first_hold", rddout2, 8'h0A);
    @(negedge rdclk);
    rdreq2 = 1'b1;
    @(negedge rdclk);
    rdreq2 = 1'b0;
    chk("nrm_second", rddout2, 8'h0B);
    wait_rd(2);
    chk("nrm_second_hold", rddout2, 8'h0B);
    chk("nrm_rdempty", rdempty2, 1);

    // Random traffic across several pointer wraps, both clock ratio orders.
    run_random(5, 13);
    run_random(13, 5);

    // Reset with data stored discards everything.
    wr_half = 5;
    rd_half = 13;
    wait_wr(4);
    for (int i = 0; i < 100; i++) wr_push(8'(i + 3));
    wr_idle();
    wait_rd(5);
    chk("pre_reset_rdusedw", rdusedw, 100);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    chk("midreset_nrm_rddout", rddout2, 0);
    exp_q.delete();
    #40;
    rst_n = 1'b1;
    wait_wr(3);
    wait_rd(3);
    check_reset("postreset");
    wr_push(8'h5A);
    wr_idle();
    wait_rd(5);
    rd_pop("after_reset");
    rd_idle();
    chk("after_reset_rdempty", rdempty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
